// File: rtl/sdpram_pkg.sv
// Shared types and constants for the byte-enable simple dual-port RAM.
// Holds the clear-FSM state encoding and the collision-policy names.
package sdpram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } init_state_t;

    localparam string MODE_WRITE_FIRST = "write_first";
    localparam string MODE_READ_FIRST  = "read_first";

endpackage

// File: rtl/sdpram_init_ctrl.sv
// Memory-clear sequencer: walks an address counter over the whole array,
// one word per cycle, on request or automatically after reset.
module sdpram_init_ctrl
    import sdpram_pkg::*;
#(
    parameter int DATA_DEPTH    = 256,
    parameter int INIT_ON_RESET = 1,
    parameter int ADDR_WIDTH    = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_i,
    output logic                  busy_o,
    output logic                  clr_we_o,
    output logic [ADDR_WIDTH-1:0] clr_addr_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    init_state_t           state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  boot_pend;

    // boot_pend turns the automatic post-reset clear into a one-shot request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            clr_cnt   <= '0;
            boot_pend <= (INIT_ON_RESET != 0);
        end else if (state == ST_IDLE) begin
            if (init_i || boot_pend) begin
                state     <= ST_CLEAR;
                clr_cnt   <= '0;
                boot_pend <= 1'b0;
            end
        end else begin
            if (clr_cnt == LAST_ADDR) begin
                state   <= ST_IDLE;
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    assign busy_o     = (state == ST_CLEAR);
    assign clr_we_o   = busy_o;
    assign clr_addr_o = clr_cnt;

endmodule

// File: rtl/byte_en_sdpram.sv
// Simple dual-port RAM with per-lane write enables, selectable collision
// policy, 1- or 2-cycle read latency and a built-in full-array clear.
module byte_en_sdpram
    import sdpram_pkg::*;
#(
    parameter int    DATA_DEPTH    = 256,
    parameter int    DATA_WIDTH    = 32,
    parameter int    BYTE_WIDTH    = 8,
    parameter string WRITE_MODE    = "write_first",
    parameter int    READ_LATENCY  = 1,
    parameter int    INIT_ON_RESET = 1,
    localparam int   ADDR_WIDTH    = $clog2(DATA_DEPTH),
    localparam int   NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_i,
    output logic                  busy_o,
    input  logic                  wr_en_i,
    input  logic [NUM_BYTES-1:0]  wr_be_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o
);

    localparam bit READ_FIRST = (WRITE_MODE == MODE_READ_FIRST);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  vld_out;
    logic [DATA_WIDTH-1:0] data_out;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (be[b]) begin
                res[b*BYTE_WIDTH +: BYTE_WIDTH] = new_word[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    sdpram_init_ctrl #(
        .DATA_DEPTH    (DATA_DEPTH),
        .INIT_ON_RESET (INIT_ON_RESET),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_i     (init_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign busy_o = busy;
    assign wr_acc = wr_en_i && !busy;
    assign rd_acc = rd_en_i && !busy;

    // Write-first bypass: merge the incoming lanes over the stored word
    assign rd_hit  = !READ_FIRST && wr_acc && (wr_addr_i == rd_addr_i);
    assign rd_word = rd_hit ? merge_lanes(mem[rd_addr_i], wr_data_i, wr_be_i)
                            : mem[rd_addr_i];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_be_i[b]) begin
                    mem[wr_addr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] data_p0;
            logic                  vld_p0;

            // Stage p0: array read captured
            always_ff @(posedge clk) begin
                if (rd_acc) begin
                    data_p0 <= rd_word;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_p0 <= 1'b0;
                end else begin
                    vld_p0 <= rd_acc;
                end
            end

            assign vld_out  = vld_p0;
            assign data_out = data_p0;
        end else begin : g_lat1
            assign vld_out  = rd_acc;
            assign data_out = rd_word;
        end
    endgenerate

    // Output stage: data holds between valid results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_valid_o <= vld_out;
            if (vld_out) begin
                rd_data_o <= data_out;
            end
        end
    end

endmodule
